// File: rtl/add_sub_arbiter_if.sv
// rtl/add_sub_arbiter_if.sv - request/result bus of the shared add/sub arbiter
// Purpose: bundles both requester ports and the result slot handshake.
// Ports (signals):
//   i_req_valid[1:0] / o_req_ready[1:0]  per-requester valid/ready
//   i_var1_k, i_var2_k, i_mode_k         operands and op select of port k (1=add)
//   o_valid / i_ready                    result slot handshake
//   o_res, o_carry, o_id                 result, carry/not-borrow, winner id
//   o_ops_cnt                            consumed-result counter
// Modports: master = requesters + downstream consumer, slave = arbiter.
interface add_sub_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [1:0]       i_req_valid;
  logic [1:0]       o_req_ready;
  logic [WIDTH-1:0] i_var1_0;
  logic [WIDTH-1:0] i_var1_1;
  logic [WIDTH-1:0] i_var2_0;
  logic [WIDTH-1:0] i_var2_1;
  logic             i_mode_0;
  logic             i_mode_1;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_res;
  logic             o_carry;
  logic             o_id;
  logic [CNT_W-1:0] o_ops_cnt;

  modport master (
    output i_req_valid, i_var1_0, i_var1_1, i_var2_0, i_var2_1,
           i_mode_0, i_mode_1, i_ready,
    input  o_req_ready, o_valid, o_res, o_carry, o_id, o_ops_cnt
  );

  modport slave (
    input  i_req_valid, i_var1_0, i_var1_1, i_var2_0, i_var2_1,
           i_mode_0, i_mode_1, i_ready,
    output o_req_ready, o_valid, o_res, o_carry, o_id, o_ops_cnt
  );
endinterface

// File: rtl/add_sub_arbiter.sv
// rtl/add_sub_arbiter.sv - round-robin arbiter sharing one add/sub datapath
// Purpose: two requesters share a WIDTH-bit adder/subtractor; the winner's result
//   lands in a single registered slot with valid/ready backpressure.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   bus    add_sub_arbiter_if.slave (requests, result slot, op counter)
module add_sub_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  add_sub_arbiter_if.slave   bus
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             consume;
  logic             gnt_vld;
  logic             gnt_id;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_add;
  logic [WIDTH:0]   sum, diff;

  // Grant: slot can take a new result when empty or being drained this cycle.
  // Gated by i_rst so no port sees ready while reset is held.
  always_comb begin
    accept  = (state_q == S_EMPTY) | bus.i_ready;
    consume = (state_q == S_FULL) & bus.i_ready;
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (accept && !i_rst) begin
      case (bus.i_req_valid)
        2'b01:   begin gnt_vld = 1'b1; gnt_id = 1'b0;   end
        2'b10:   begin gnt_vld = 1'b1; gnt_id = 1'b1;   end
        2'b11:   begin gnt_vld = 1'b1; gnt_id = prio_q; end
        default: begin gnt_vld = 1'b0; gnt_id = 1'b0;   end
      endcase
    end
  end

  assign bus.o_req_ready = {gnt_vld & gnt_id, gnt_vld & ~gnt_id};

  // Shared datapath: operands muxed by the grant, both ops computed WIDTH+1 wide.
  always_comb begin
    op_a   = gnt_id ? bus.i_var1_1 : bus.i_var1_0;
    op_b   = gnt_id ? bus.i_var2_1 : bus.i_var2_0;
    op_add = gnt_id ? bus.i_mode_1 : bus.i_mode_0;
    sum    = {1'b0, op_a} + {1'b0, op_b};
    diff   = {1'b0, op_a} - {1'b0, op_b};
  end

  // Next state: a handshake refills the slot (even while it drains), otherwise a
  // drain empties it. Priority only moves on a grant.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    res_d   = res_q;
    carry_d = carry_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    if (gnt_vld) begin
      state_d = S_FULL;
      res_d   = op_add ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
      carry_d = op_add ? sum[WIDTH] : ~diff[WIDTH];
      id_d    = gnt_id;
      prio_d  = ~gnt_id;
    end else if (consume) begin
      state_d = S_EMPTY;
    end
    if (consume) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_EMPTY;
      prio_q  <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_valid   = (state_q == S_FULL);
  assign bus.o_res     = res_q;
  assign bus.o_carry   = carry_q;
  assign bus.o_id      = id_q;
  assign bus.o_ops_cnt = cnt_q;

endmodule

// File: tb/tb_add_sub_arbiter.sv
// tb/tb_add_sub_arbiter.sv - self-checking bench for add_sub_arbiter
module tb_add_sub_arbiter;

  logic clk;
  logic rst;

  add_sub_arbiter_if #(.WIDTH(4), .CNT_W(8)) bus ();
  add_sub_arbiter_if #(.WIDTH(4), .CNT_W(3)) bus3 ();

  add_sub_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  add_sub_arbiter #(.WIDTH(4), .CNT_W(3)) dut3 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus3)
  );

  assign bus3.i_req_valid = bus.i_req_valid;
  assign bus3.i_var1_0    = bus.i_var1_0;
  assign bus3.i_var1_1    = bus.i_var1_1;
  assign bus3.i_var2_0    = bus.i_var2_0;
  assign bus3.i_var2_1    = bus.i_var2_1;
  assign bus3.i_mode_0    = bus.i_mode_0;
  assign bus3.i_mode_1    = bus.i_mode_1;
  assign bus3.i_ready     = bus.i_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit m_full;
  int m_res, m_carry, m_id, m_prio, m_cnt;

  typedef struct {
    bit       port;
    bit       mode;
    int       a;
    int       b;
    int       res;
    int       carry;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_full = 0; m_res = 0; m_carry = 0; m_id = 0; m_prio = 0; m_cnt = 0;
  endtask

  // One clock: compare DUT with the model at the falling edge, advance the model,
  // then return 1 time unit after the rising edge.
  task automatic tick();
    bit acc, gv, md;
    int g, a, b, s;
    @(negedge clk);
    acc = !m_full || bus.i_ready;
    gv = 0; g = 0;
    if (acc) begin
      if (bus.i_req_valid == 2'b11) begin gv = 1; g = m_prio; end
      else if (bus.i_req_valid == 2'b01) begin gv = 1; g = 0; end
      else if (bus.i_req_valid == 2'b10) begin gv = 1; g = 1; end
    end
    chk("req_ready", int'(bus.o_req_ready), gv ? (1 << g) : 0);
    chk("o_valid", int'(bus.o_valid), int'(m_full));
    if (m_full) begin
      chk("o_res", int'(bus.o_res), m_res);
      chk("o_carry", int'(bus.o_carry), m_carry);
      chk("o_id", int'(bus.o_id), m_id);
    end
    chk("ops_cnt", int'(bus.o_ops_cnt), m_cnt % 256);
    chk("ops_cnt_w3", int'(bus3.o_ops_cnt), m_cnt % 8);
    if (m_full && bus.i_ready) m_cnt++;
    if (gv) begin
      a  = (g == 1) ? int'(bus.i_var1_1) : int'(bus.i_var1_0);
      b  = (g == 1) ? int'(bus.i_var2_1) : int'(bus.i_var2_0);
      md = (g == 1) ? bus.i_mode_1 : bus.i_mode_0;
      if (md) begin
        s = a + b;
        m_res = s % 16;
        m_carry = (s > 15) ? 1 : 0;
      end else begin
        m_res = (a - b + 16) % 16;
        m_carry = (a >= b) ? 1 : 0;
      end
      m_full = 1; m_id = g; m_prio = 1 - g;
    end else if (m_full && bus.i_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_res", int'(bus.o_res), 0);
    chk("rst_carry", int'(bus.o_carry), 0);
    chk("rst_id", int'(bus.o_id), 0);
    chk("rst_cnt", int'(bus.o_ops_cnt), 0);
    chk("rst_req_ready", int'(bus.o_req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic set_port(bit p, bit mode, int a, int b);
    if (p) begin
      bus.i_var1_1 = 4'(a); bus.i_var2_1 = 4'(b); bus.i_mode_1 = mode;
    end else begin
      bus.i_var1_0 = 4'(a); bus.i_var2_0 = 4'(b); bus.i_mode_0 = mode;
    end
  endtask

  initial begin
    int stall_res;
    rst = 1'b0;
    bus.i_req_valid = 2'b00;
    bus.i_var1_0 = '0; bus.i_var1_1 = '0;
    bus.i_var2_0 = '0; bus.i_var2_1 = '0;
    bus.i_mode_0 = 1'b0; bus.i_mode_1 = 1'b0;
    bus.i_ready = 1'b1;
    model_clear();

    tbl[0] = '{1'b0, 1'b1, 9, 8, 1, 1};
    tbl[1] = '{1'b1, 1'b0, 3, 5, 14, 0};
    tbl[2] = '{1'b1, 1'b0, 5, 5, 0, 1};
    tbl[3] = '{1'b0, 1'b0, 0, 15, 1, 0};
    tbl[4] = '{1'b1, 1'b1, 15, 15, 14, 1};
    tbl[5] = '{1'b0, 1'b1, 7, 8, 15, 0};

    do_reset();

    // Table vectors: single request, result one cycle later, then drained.
    for (int i = 0; i < 6; i++) begin
      set_port(tbl[i].port, tbl[i].mode, tbl[i].a, tbl[i].b);
      bus.i_req_valid = tbl[i].port ? 2'b10 : 2'b01;
      bus.i_ready = 1'b1;
      tick();
      bus.i_req_valid = 2'b00;
      chk("tbl_valid", int'(bus.o_valid), 1);
      chk("tbl_res", int'(bus.o_res), tbl[i].res);
      chk("tbl_carry", int'(bus.o_carry), tbl[i].carry);
      chk("tbl_id", int'(bus.o_id), int'(tbl[i].port));
      tick();
    end

    // Reset in the middle of a held result with both ports requesting.
    set_port(0, 1, 2, 3);
    set_port(1, 0, 9, 4);
    bus.i_req_valid = 2'b01;
    tick();
    bus.i_ready = 1'b0;
    bus.i_req_valid = 2'b11;
    tick();
    do_reset();
    chk("post_rst_valid", int'(bus.o_valid), 0);
    bus.i_req_valid = 2'b00;
    bus.i_ready = 1'b1;
    tick();

    // Both ports request continuously: grants alternate starting with port 0.
    do_reset();
    bus.i_req_valid = 2'b11;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1, i, 1);
      set_port(1, 0, i, 1);
      #1;
      chk("rr_grant", int'(bus.o_req_ready), (i % 2 == 0) ? 1 : 2);
      tick();
    end
    bus.i_req_valid = 2'b00;
    tick();
    chk("rr_cnt", int'(bus.o_ops_cnt), 6);
    chk("rr_empty", int'(bus.o_valid), 0);

    // Backpressure: held result stays stable, queued request waits then enters.
    do_reset();
    set_port(0, 1, 9, 8);
    bus.i_req_valid = 2'b01;
    tick();
    stall_res = m_res;
    bus.i_ready = 1'b0;
    set_port(1, 0, 3, 5);
    bus.i_req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_ready", int'(bus.o_req_ready), 0);
      tick();
      chk("stall_res", int'(bus.o_res), stall_res);
    end
    bus.i_ready = 1'b1;
    #1;
    chk("release_ready", int'(bus.o_req_ready), 2);
    tick();
    bus.i_req_valid = 2'b00;
    chk("release_id", int'(bus.o_id), 1);
    chk("release_res", int'(bus.o_res), 14);
    tick();

    // Counter wrap on the CNT_W=3 instance after nine consumed results.
    do_reset();
    bus.i_req_valid = 2'b01;
    set_port(0, 1, 1, 1);
    for (int i = 0; i < 9; i++) tick();
    bus.i_req_valid = 2'b00;
    tick();
    chk("cnt9", int'(bus.o_ops_cnt), 9);
    chk("cnt_w3_wrap", int'(bus3.o_ops_cnt), 1);

    // Exhaustive operands, both modes, both ports, back to back.
    do_reset();
    bus.i_ready = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int md = 0; md < 2; md++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            set_port(p[0], md[0], a, b);
            bus.i_req_valid = p[0] ? 2'b10 : 2'b01;
            tick();
          end
    bus.i_req_valid = 2'b00;
    tick();

    // Random traffic with random backpressure and valid drops.
    for (int i = 0; i < 3000; i++) begin
      bus.i_req_valid = 2'($urandom_range(0, 3));
      set_port(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
      set_port(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
      bus.i_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
